// File: rtl/dne_axil_pkg.sv
// dne_axil_pkg
//   Shared constants, state encodings and helpers for the DNESearcher_Small_6Reg
//   AXI4-Lite register file. Imported by dne_axil_wr_chan and dne_axil_regfile_slave.
package dne_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] REG_GP0    = 3'd0;
    localparam logic [2:0] REG_GP1    = 3'd1;
    localparam logic [2:0] REG_GP2    = 3'd2;
    localparam logic [2:0] REG_GP3    = 3'd3;
    localparam logic [2:0] REG_CTRL   = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;

    localparam int CTRL_START_BIT = 0;

    typedef enum logic [1:0] {
        W_IDLE      = 2'b00,
        W_HAVE_ADDR = 2'b01,
        W_HAVE_DATA = 2'b10,
        W_RESP      = 2'b11
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Merge new_val into old_val on the byte lanes enabled by strb.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dne_axil_wr_chan.sv
// dne_axil_wr_chan
//   AXI4-Lite write channel: AW/W handshakes in either order, address/data
//   latches, single outstanding write, B response generation.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   W_IDLE       | ready for both AW and W
//   W_HAVE_ADDR  | address latched, waiting on W
//   W_HAVE_DATA  | data/strobe latched, waiting on AW
//   W_RESP       | BVALID high, holding BRESP until BREADY
//
//   Ports
//     clk, rst                       clock, async active-high reset
//     aw_idx/aw_valid/aw_ready       word index (addr[4:2]) and handshake
//     w_data/w_strb/w_valid/w_ready  write data channel
//     b_resp/b_valid/b_ready         write response channel
//     commit, commit_idx/data/strb   one-cycle strobe on the edge both halves are held
module dne_axil_wr_chan
    import dne_axil_pkg::*;
#(
    parameter int NUM_REGS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  aw_idx,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    input  logic        w_valid,
    output logic        w_ready,
    output logic [1:0]  b_resp,
    output logic        b_valid,
    input  logic        b_ready,
    output logic        commit,
    output logic [2:0]  commit_idx,
    output logic [31:0] commit_data,
    output logic [3:0]  commit_strb
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

    wr_state_t   state_q, state_d;
    logic [2:0]  idx_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;
    logic        aw_ready_q, w_ready_q;
    logic [1:0]  b_resp_q;
    logic        aw_hs, w_hs;

    assign aw_hs = aw_valid && aw_ready_q;
    assign w_hs  = w_valid && w_ready_q;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d = W_RESP;
                    commit  = 1'b1;
                end else if (aw_hs) begin
                    state_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    state_d = W_RESP;
                    commit  = 1'b1;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    state_d = W_RESP;
                    commit  = 1'b1;
                end
            end
            W_RESP: begin
                if (b_ready) state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

    // Whichever half arrived first comes from its latch, the other straight off the bus.
    assign commit_idx  = (state_q == W_HAVE_ADDR) ? idx_q  : aw_idx;
    assign commit_data = (state_q == W_HAVE_DATA) ? data_q : w_data;
    assign commit_strb = (state_q == W_HAVE_DATA) ? strb_q : w_strb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= W_IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            state_q    <= state_d;
            // Readies are registered so they stay low until the first edge out of reset.
            aw_ready_q <= (state_d == W_IDLE) || (state_d == W_HAVE_DATA);
            w_ready_q  <= (state_d == W_IDLE) || (state_d == W_HAVE_ADDR);
            if (aw_hs) idx_q <= aw_idx;
            if (w_hs) begin
                data_q <= w_data;
                strb_q <= w_strb;
            end
            if (commit) b_resp_q <= (commit_idx <= LAST_IDX) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q;
    assign b_valid  = (state_q == W_RESP);
    assign b_resp   = b_resp_q;

endmodule

// File: rtl/dne_axil_regfile_slave.sv
// dne_axil_regfile_slave
//   AXI4-Lite register file for the DNESearcher_Small_6Reg peripheral.
//   Words: 0-3 general RW, 4 CTRL (bit0 write-1-to-pulse start_o), 5 STATUS (RO,
//   returns status_i), 6-7 unmapped (SLVERR).
//
//   read state | meaning
//   -----------+---------------------------------------
//   R_IDLE     | ARREADY high, waiting on AR
//   R_DATA     | RVALID high, holding RDATA/RRESP until RREADY
//
//   Ports
//     S_AXI_ACLK, S_AXI_ARESET   clock, async active-high reset
//     S_AXI_AW*/W*/B*            write address, data and response channels
//     S_AXI_AR*/R*               read address and data channels
//     gp_regs_o                  {reg3, reg2, reg1, reg0}
//     ctrl_o                     reg4 contents
//     start_o                    one-cycle pulse after a start write commits
//     status_i                   value returned on reads of reg5
module dne_axil_regfile_slave
    import dne_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 6
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [127:0]                    gp_regs_o,
    output logic [31:0]                     ctrl_o,
    output logic                            start_o,
    input  logic [31:0]                     status_i
);

    logic        unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    logic        commit;
    logic [2:0]  commit_idx;
    logic [31:0] commit_data;
    logic [3:0]  commit_strb;

    dne_axil_wr_chan #(
        .NUM_REGS (NUM_REGS)
    ) u_wr_chan (
        .clk         (S_AXI_ACLK),
        .rst         (S_AXI_ARESET),
        .aw_idx      (S_AXI_AWADDR[4:2]),
        .aw_valid    (S_AXI_AWVALID),
        .aw_ready    (S_AXI_AWREADY),
        .w_data      (S_AXI_WDATA),
        .w_strb      (S_AXI_WSTRB),
        .w_valid     (S_AXI_WVALID),
        .w_ready     (S_AXI_WREADY),
        .b_resp      (S_AXI_BRESP),
        .b_valid     (S_AXI_BVALID),
        .b_ready     (S_AXI_BREADY),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb)
    );

    logic [31:0] gp_q [0:3];
    logic [31:0] ctrl_q;
    logic [31:0] ctrl_wr_val;
    logic        start_q;

    // The start bit is never stored; it only fires the pulse.
    always_comb begin
        ctrl_wr_val = apply_wstrb(ctrl_q, commit_data, commit_strb);
        ctrl_wr_val[CTRL_START_BIT] = 1'b0;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < 4; i++) gp_q[i] <= '0;
            ctrl_q  <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (commit) begin
                case (commit_idx)
                    REG_GP0, REG_GP1, REG_GP2, REG_GP3:
                        gp_q[commit_idx[1:0]] <= apply_wstrb(gp_q[commit_idx[1:0]], commit_data, commit_strb);
                    REG_CTRL: begin
                        ctrl_q  <= ctrl_wr_val;
                        start_q <= commit_strb[CTRL_START_BIT/8] && commit_data[CTRL_START_BIT];
                    end
                    default: ;
                endcase
            end
        end
    end

    rd_state_t   rd_state_q;
    logic        ar_ready_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        ar_hs;
    logic [2:0]  ar_idx;
    logic [31:0] rd_mux_data;
    logic [1:0]  rd_mux_resp;

    assign ar_idx = S_AXI_ARADDR[4:2];
    assign ar_hs  = S_AXI_ARVALID && ar_ready_q;

    // Muxes the pre-edge register values, so a same-edge write is not visible here.
    always_comb begin
        rd_mux_data = '0;
        rd_mux_resp = RESP_OKAY;
        case (ar_idx)
            REG_GP0, REG_GP1, REG_GP2, REG_GP3: rd_mux_data = gp_q[ar_idx[1:0]];
            REG_CTRL:   rd_mux_data = ctrl_q;
            REG_STATUS: rd_mux_data = status_i;
            default:    rd_mux_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rd_state_q <= R_IDLE;
            ar_ready_q <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    ar_ready_q <= ~ar_hs;
                    if (ar_hs) begin
                        rd_state_q <= R_DATA;
                        rdata_q    <= rd_mux_data;
                        rresp_q    <= rd_mux_resp;
                    end
                end
                R_DATA: begin
                    ar_ready_q <= S_AXI_RREADY;
                    if (S_AXI_RREADY) rd_state_q <= R_IDLE;
                end
                default: begin
                    rd_state_q <= R_IDLE;
                    ar_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = (rd_state_q == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign gp_regs_o = {gp_q[3], gp_q[2], gp_q[1], gp_q[0]};
    assign ctrl_o    = ctrl_q;
    assign start_o   = start_q;

endmodule

// File: tb/tb_dne_axil_regfile_slave.sv
// tb_dne_axil_regfile_slave
//   Directed bench for dne_axil_regfile_slave: sequential write/readback,
//   split AW/W timing, byte strobes, start pulse, status/unmapped access,
//   response stalls and mid-transaction reset.
module tb_dne_axil_regfile_slave;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [4:0]   awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [4:0]   araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [127:0] gp_regs;
    logic [31:0]  ctrl;
    logic         start;
    logic [31:0]  status = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (start) start_cnt <= start_cnt + 1;

    dne_axil_regfile_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .gp_regs_o     (gp_regs),
        .ctrl_o        (ctrl),
        .start_o       (start),
        .status_i      (status)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1, returns at posedge+1.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int  n;
        logic aw_take, w_take, got;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            @(negedge clk);
            aw_take = awvalid && awready;
            w_take  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_take) awvalid = 1'b0;
            if (w_take)  wvalid  = 1'b0;
            n++;
        end
        if (awvalid || wvalid) chk("wr_addr_data_timeout", 1, 0);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0; got = 1'b0; resp = 2'bxx;
        while (!got && n < 20) begin
            @(negedge clk);
            if (bvalid) begin got = 1'b1; resp = bresp; end
            @(posedge clk); #1;
            n++;
        end
        if (!got) chk("wr_resp_timeout", 1, 0);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int  n;
        logic taken, got;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0; taken = 1'b0;
        while (!taken && n < 20) begin
            @(negedge clk);
            taken = arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        if (!taken) chk("rd_addr_timeout", 1, 0);
        n = 0; got = 1'b0; d = 'x; resp = 2'bxx;
        while (!got && n < 20) begin
            @(negedge clk);
            if (rvalid) begin got = 1'b1; d = rdata; resp = rresp; end
            @(posedge clk); #1;
            n++;
        end
        if (!got) chk("rd_data_timeout", 1, 0);
        rready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        int          s0;

        // reset
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readies", {awready, wready, arready}, 3'b000);
        chk("rst_valids", {bvalid, rvalid}, 2'b00);
        chk("rst_resps", {bresp, rresp}, 4'b0000);
        chk("rst_rdata", rdata, 0);
        chk("rst_gp_regs", gp_regs, 0);
        chk("rst_ctrl_start", {ctrl, start}, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_readies", {awready, wready, arready}, 3'b111);

        // sequential write / readback
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp);
            chk("seq_bresp", resp, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), d, resp);
            chk("seq_rdata", d, 32'(i + 1));
            chk("seq_rresp", resp, 2'b00);
        end
        chk("seq_gp_regs", gp_regs, 128'h00000004_00000003_00000002_00000001);

        // AW three cycles ahead of W
        awaddr = 5'h08; awvalid = 1'b1;
        @(negedge clk);
        chk("split_awready_idle", awready, 1);
        @(posedge clk); #1 awvalid = 1'b0;
        @(negedge clk);
        chk("split_awready_drop", awready, 0);
        chk("split_wready_hold", wready, 1);
        repeat (2) @(posedge clk);
        #1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        chk("split_wready", wready, 1);
        chk("split_bvalid_pre", bvalid, 0);
        @(posedge clk); #1 wvalid = 1'b0;
        @(negedge clk);
        chk("split_bvalid_lat1", bvalid, 1);
        chk("split_bresp", bresp, 2'b00);
        chk("split_commit", gp_regs[95:64], 32'hDEADBEEF);
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        chk("split_bvalid_clear", bvalid, 0);
        @(posedge clk); #1;
        axi_read(5'h08, d, resp);
        chk("split_readback", d, 32'hDEADBEEF);

        // byte strobes
        axi_write(5'h04, 32'h0, 4'hF, resp);
        axi_write(5'h04, 32'hFFFFFFFF, 4'h5, resp);
        chk("strb_bresp", resp, 2'b00);
        axi_read(5'h04, d, resp);
        chk("strb_readback", d, 32'h00FF00FF);

        // start pulse
        s0 = start_cnt;
        axi_write(5'h10, 32'h00000103, 4'hF, resp);
        repeat (3) @(posedge clk);
        #1;
        chk("start_pulse_count", start_cnt - s0, 1);
        axi_read(5'h10, d, resp);
        chk("ctrl_readback", d, 32'h00000102);
        chk("ctrl_o", ctrl, 32'h00000102);
        repeat (2) @(posedge clk);
        #1;
        chk("start_no_read_pulse", start_cnt - s0, 1);

        // status, read-only and unmapped
        status = 32'hA5A50001;
        axi_read(5'h14, d, resp);
        chk("status_rdata", d, 32'hA5A50001);
        chk("status_rresp", resp, 2'b00);
        axi_write(5'h14, 32'h12345678, 4'hF, resp);
        chk("status_wr_bresp", resp, 2'b00);
        chk("status_wr_gp", gp_regs, 128'h00000004_DEADBEEF_00FF00FF_00000001);
        chk("status_wr_ctrl", ctrl, 32'h00000102);
        axi_read(5'h14, d, resp);
        chk("status_after_wr", d, 32'hA5A50001);
        axi_read(5'h18, d, resp);
        chk("unmapped_rdata", d, 0);
        chk("unmapped_rresp", resp, 2'b10);
        axi_write(5'h1C, 32'hFFFFFFFF, 4'hF, resp);
        chk("unmapped_bresp", resp, 2'b10);
        chk("unmapped_wr_gp", gp_regs, 128'h00000004_DEADBEEF_00FF00FF_00000001);

        // response stall, then reset mid-transaction
        awaddr = 5'h00; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h04; arvalid = 1'b1;
        @(negedge clk);
        chk("stall_readies", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_b", {bvalid, bresp}, 3'b100);
            chk("stall_r", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'h00FF00FF});
        end
        chk("stall_commit", gp_regs[31:0], 32'h11);
        #2 rst = 1'b1;
        #1;
        chk("arst_valids", {bvalid, rvalid}, 2'b00);
        chk("arst_gp_regs", gp_regs, 0);
        chk("arst_ctrl_rdata", {ctrl, rdata}, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        axi_read(5'h08, d, resp);
        chk("post_rst_read", {d, resp}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
